// File: rtl/light_zone_if.sv
// Panel-side bundle for the lighting controller: per-zone buttons/enables and the shared
// sunlight sample in, per-zone lamp levels/colours and the shared target level out.
interface light_zone_if #(
    parameter int NUM_ZONES = 4,
    parameter int SENSOR_W  = 8
);
    logic [NUM_ZONES-1:0]   color_button;
    logic [NUM_ZONES-1:0]   zone_en;
    logic [SENSOR_W-1:0]    sunlight_sensor;
    logic [2*NUM_ZONES-1:0] luminosity;
    logic [2*NUM_ZONES-1:0] color;
    logic [1:0]             target_lvl;

    modport master (
        output color_button, zone_en, sunlight_sensor,
        input  luminosity, color, target_lvl
    );

    modport slave (
        input  color_button, zone_en, sunlight_sensor,
        output luminosity, color, target_lvl
    );
endinterface

// File: rtl/light_zone_ctrl.sv
// Multi-zone lighting controller: hysteresis-filtered shared target level, per-zone ramp
// toward it on prescaler ticks, and per-zone debounced colour buttons.
module light_zone_ctrl #(
    parameter int NUM_ZONES  = 4,
    parameter int SENSOR_W   = 8,
    parameter int NUM_COLORS = 4,
    parameter int TH1        = 15,
    parameter int TH2        = 30,
    parameter int TH3        = 50,
    parameter int HYST       = 2,
    parameter int DEBOUNCE   = 4,
    parameter int RAMP_DIV   = 16
) (
    input  logic         clk,
    input  logic         reset,
    light_zone_if.slave  bus
);
    localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int PSW = $clog2(RAMP_DIV);
    localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE - 1);
    localparam logic [PSW-1:0] PS_MAX  = PSW'(RAMP_DIV - 1);
    localparam logic [1:0]     CLR_MAX = 2'(NUM_COLORS - 1);

    logic [NUM_ZONES-1:0] sync1_q, sync1_d;
    logic [NUM_ZONES-1:0] sync2_q, sync2_d;
    logic [NUM_ZONES-1:0] deb_q, deb_d;
    logic [DBW-1:0]       cnt_q   [NUM_ZONES];
    logic [DBW-1:0]       cnt_d   [NUM_ZONES];
    logic [1:0]           color_q [NUM_ZONES];
    logic [1:0]           color_d [NUM_ZONES];
    logic [1:0]           lum_q   [NUM_ZONES];
    logic [1:0]           lum_d   [NUM_ZONES];
    logic [PSW-1:0]       ps_q, ps_d;
    logic [1:0]           target_q, target_d;
    logic [1:0]           up_lvl_s, dn_lvl_s;
    logic                 tick_s;

    // Level 3 below the first threshold, stepping down to 0 at or above the third.
    function automatic logic [1:0] classify(input logic [SENSOR_W-1:0] s,
                                            input int t1, input int t2, input int t3);
        int v;
        v = int'(s);
        if (v < t1) begin
            classify = 2'd3;
        end else if (v < t2) begin
            classify = 2'd2;
        end else if (v < t3) begin
            classify = 2'd1;
        end else begin
            classify = 2'd0;
        end
    endfunction

    // Shared target with hysteresis, plus the ramp prescaler.
    always_comb begin
        up_lvl_s = classify(bus.sunlight_sensor, TH1 - HYST, TH2 - HYST, TH3 - HYST);
        dn_lvl_s = classify(bus.sunlight_sensor, TH1 + HYST, TH2 + HYST, TH3 + HYST);
        target_d = target_q;
        if (up_lvl_s > target_q) begin
            target_d = up_lvl_s;
        end else if (dn_lvl_s < target_q) begin
            target_d = dn_lvl_s;
        end else begin
            target_d = target_q;
        end
        tick_s = (ps_q == PS_MAX);
        if (tick_s) begin
            ps_d = {PSW{1'b0}};
        end else begin
            ps_d = ps_q + PSW'(1);
        end
    end

    // Per-zone button synchroniser, debouncer, colour stepping and lamp ramp.
    always_comb begin
        sync1_d = bus.color_button;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int z = 0; z < NUM_ZONES; z++) begin
            cnt_d[z]   = cnt_q[z];
            color_d[z] = color_q[z];
            lum_d[z]   = lum_q[z];
            if (sync2_q[z] != deb_q[z]) begin
                if (cnt_q[z] == DB_MAX) begin
                    deb_d[z] = sync2_q[z];
                    cnt_d[z] = {DBW{1'b0}};
                end else begin
                    cnt_d[z] = cnt_q[z] + DBW'(1);
                end
            end else begin
                cnt_d[z] = {DBW{1'b0}};
            end
            // Colour steps only on a debounced press, and is frozen while the zone is disabled.
            if (deb_d[z] && !deb_q[z] && bus.zone_en[z]) begin
                color_d[z] = (color_q[z] == CLR_MAX) ? 2'd0 : color_q[z] + 2'd1;
            end else begin
                color_d[z] = color_q[z];
            end
            if (!bus.zone_en[z]) begin
                lum_d[z] = 2'd0;
            end else if (tick_s) begin
                if (lum_q[z] < target_q) begin
                    lum_d[z] = lum_q[z] + 2'd1;
                end else if (lum_q[z] > target_q) begin
                    lum_d[z] = lum_q[z] - 2'd1;
                end else begin
                    lum_d[z] = lum_q[z];
                end
            end else begin
                lum_d[z] = lum_q[z];
            end
        end
    end

    // State registers; reset clears every stage at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= {NUM_ZONES{1'b0}};
            sync2_q  <= {NUM_ZONES{1'b0}};
            deb_q    <= {NUM_ZONES{1'b0}};
            ps_q     <= {PSW{1'b0}};
            target_q <= 2'd0;
            for (int z = 0; z < NUM_ZONES; z++) begin
                cnt_q[z]   <= {DBW{1'b0}};
                color_q[z] <= 2'd0;
                lum_q[z]   <= 2'd0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            ps_q     <= ps_d;
            target_q <= target_d;
            for (int z = 0; z < NUM_ZONES; z++) begin
                cnt_q[z]   <= cnt_d[z];
                color_q[z] <= color_d[z];
                lum_q[z]   <= lum_d[z];
            end
        end
    end

    assign bus.target_lvl = target_q;

    for (genvar g = 0; g < NUM_ZONES; g++) begin : g_out
        assign bus.luminosity[2*g +: 2] = lum_q[g];
        assign bus.color[2*g +: 2]      = color_q[g];
    end
endmodule

// File: tb/tb_light_zone_ctrl.sv
// Self-checking bench for light_zone_ctrl: directed tables and sequences plus random
// stimulus compared every cycle against a behavioural model of the controller.
module tb_light_zone_ctrl;
    localparam int NZ   = 4;
    localparam int SW   = 8;
    localparam int NC   = 4;
    localparam int TH1  = 15;
    localparam int TH2  = 30;
    localparam int TH3  = 50;
    localparam int HYST = 2;
    localparam int DEB  = 4;
    localparam int RDIV = 16;

    logic clk;
    logic reset;
    light_zone_if #(.NUM_ZONES(NZ), .SENSOR_W(SW)) bus ();

    light_zone_ctrl #(
        .NUM_ZONES(NZ), .SENSOR_W(SW), .NUM_COLORS(NC), .TH1(TH1), .TH2(TH2), .TH3(TH3),
        .HYST(HYST), .DEBOUNCE(DEB), .RAMP_DIV(RDIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_target;
    int m_edges;
    int m_lum [NZ];
    int m_col [NZ];
    int m_run [NZ];
    bit m_deb [NZ];
    bit m_hist [NZ][2];

    typedef struct {
        int sensor;
        int exp_target;
    } tgt_vec_t;
    tgt_vec_t tv [13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lvl_of(input int s, input int off);
        int n;
        n = 0;
        if (s >= TH1 + off) n++;
        if (s >= TH2 + off) n++;
        if (s >= TH3 + off) n++;
        return 3 - n;
    endfunction

    task automatic model_reset();
        m_target = 0;
        m_edges  = 0;
        for (int z = 0; z < NZ; z++) begin
            m_lum[z] = 0; m_col[z] = 0; m_run[z] = 0; m_deb[z] = 1'b0;
            m_hist[z][0] = 1'b0; m_hist[z][1] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit tick;
        int up, dn, nt;
        tick = (m_edges % RDIV) == RDIV - 1;
        up = lvl_of(int'(bus.sunlight_sensor), -HYST);
        dn = lvl_of(int'(bus.sunlight_sensor), HYST);
        nt = (up > m_target) ? up : ((dn < m_target) ? dn : m_target);
        for (int z = 0; z < NZ; z++) begin
            if (!bus.zone_en[z]) m_lum[z] = 0;
            else if (tick && m_target > m_lum[z]) m_lum[z]++;
            else if (tick && m_target < m_lum[z]) m_lum[z]--;
            // m_hist[z][1] is the button as seen two edges ago (synchroniser output)
            if (m_hist[z][1] != m_deb[z]) begin
                m_run[z]++;
                if (m_run[z] == DEB) begin
                    m_deb[z] = m_hist[z][1];
                    m_run[z] = 0;
                    if (m_deb[z] && bus.zone_en[z]) m_col[z] = (m_col[z] + 1) % NC;
                end
            end else begin
                m_run[z] = 0;
            end
            m_hist[z][1] = m_hist[z][0];
            m_hist[z][0] = bus.color_button[z];
        end
        m_edges++;
        m_target = nt;
    endtask

    task automatic compare_model();
        int el, ec;
        el = 0; ec = 0;
        for (int z = 0; z < NZ; z++) begin
            el = el | (m_lum[z] << (2*z));
            ec = ec | (m_col[z] << (2*z));
        end
        check("model_luminosity", int'(bus.luminosity), el);
        check("model_color", int'(bus.color), ec);
        check("model_target", int'(bus.target_lvl), m_target);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic zone_lum(input int z, output int v);
        v = int'(bus.luminosity[2*z +: 2]);
    endtask

    // Cold start: after reset release, sensor 10 and all zones enabled.
    task automatic cold_start();
        reset = 1'b1;
        bus.color_button = '0;
        bus.zone_en = '1;
        bus.sunlight_sensor = 8'd10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int e = 1; e <= 3*RDIV; e++) begin
            step();
            if (e == 1)          check("cold_target", int'(bus.target_lvl), 3);
            if (e == RDIV - 1)   check("cold_pre_tick", int'(bus.luminosity), 8'h00);
            if (e == RDIV)       check("cold_tick1", int'(bus.luminosity), 8'h55);
            if (e == 2*RDIV)     check("cold_tick2", int'(bus.luminosity), 8'hAA);
            if (e == 3*RDIV)     check("cold_tick3", int'(bus.luminosity), 8'hFF);
        end
    endtask

    int hold_left [NZ];
    int v, prev;

    initial begin
        tv[0]  = '{10, 3};  tv[1]  = '{20, 2};  tv[2]  = '{14, 2};  tv[3]  = '{12, 3};
        tv[4]  = '{16, 3};  tv[5]  = '{17, 2};  tv[6]  = '{60, 0};  tv[7]  = '{49, 0};
        tv[8]  = '{47, 1};  tv[9]  = '{51, 1};  tv[10] = '{52, 0};  tv[11] = '{0, 3};
        tv[12] = '{255, 0};

        reset = 1'b1;
        bus.color_button = '0;
        bus.zone_en = '0;
        bus.sunlight_sensor = '0;
        #2;
        check("reset_lum", int'(bus.luminosity), 0);
        check("reset_color", int'(bus.color), 0);
        check("reset_target", int'(bus.target_lvl), 0);

        cold_start();

        // Hysteresis table
        for (int i = 0; i < 13; i++) begin
            bus.sunlight_sensor = SW'(tv[i].sensor);
            step();
            check($sformatf("target_vec%0d", i), int'(bus.target_lvl), tv[i].exp_target);
        end

        // Four 10-cycle presses on zone 1, colour steps exactly DEBOUNCE+1 edges after capture
        for (int p = 1; p <= 4; p++) begin
            bus.color_button[1] = 1'b1;
            for (int i = 0; i < 10; i++) begin
                step();
                if (i == DEB)     check("press_early", int'(bus.color[3:2]), (p - 1) % NC);
                if (i == DEB + 1) check("press_edge", int'(bus.color[3:2]), p % NC);
            end
            bus.color_button[1] = 1'b0;
            repeat (10) step();
            check("release_hold", int'(bus.color[3:2]), p % NC);
        end

        // Three-cycle glitch on zone 0 is ignored, and a following press has full latency
        bus.color_button[0] = 1'b1;
        repeat (3) step();
        bus.color_button[0] = 1'b0;
        repeat (8) step();
        check("glitch_color", int'(bus.color[1:0]), 0);
        bus.color_button[0] = 1'b1;
        for (int i = 0; i <= DEB + 1; i++) begin
            step();
            if (i == DEB)     check("post_glitch_early", int'(bus.color[1:0]), 0);
            if (i == DEB + 1) check("post_glitch_edge", int'(bus.color[1:0]), 1);
        end
        bus.color_button[0] = 1'b0;
        repeat (6) step();

        // Zone 2 disable for one cycle, then ramp back 1,2,3
        bus.sunlight_sensor = 8'd10;
        repeat (4*RDIV) step();
        check("z2_full", int'(bus.luminosity), 8'hFF);
        bus.zone_en[2] = 1'b0;
        step();
        check("z2_off_others", int'(bus.luminosity), 8'hCF);
        bus.zone_en[2] = 1'b1;
        prev = 0;
        for (int i = 0; i < 3*RDIV + 2 && prev != 3; i++) begin
            step();
            zone_lum(2, v);
            if (v != prev) begin
                check("z2_ramp_step", v, prev + 1);
                prev = v;
            end
        end
        check("z2_ramp_done", prev, 3);

        // Random traffic against the model
        for (int z = 0; z < NZ; z++) hold_left[z] = $urandom_range(1, 12);
        for (int c = 0; c < 3000; c++) begin
            for (int z = 0; z < NZ; z++) begin
                hold_left[z]--;
                if (hold_left[z] == 0) begin
                    bus.color_button[z] = ~bus.color_button[z];
                    hold_left[z] = $urandom_range(1, 12);
                end
                bus.zone_en[z] = ($urandom_range(0, 99) >= 3);
            end
            if ($urandom_range(0, 7) == 0) begin
                bus.sunlight_sensor = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 255))
                                                                  : SW'($urandom_range(8, 58));
            end
            step();
        end

        // Asynchronous reset mid-ramp and mid-debounce
        bus.zone_en = '1;
        bus.sunlight_sensor = 8'd255;
        repeat (RDIV + 3) step();
        bus.sunlight_sensor = 8'd10;
        bus.color_button = '1;
        repeat (RDIV + 3) step();
        bus.color_button = '0;
        repeat (6) step();
        bus.color_button = '1;
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        check("async_lum", int'(bus.luminosity), 0);
        check("async_color", int'(bus.color), 0);
        check("async_target", int'(bus.target_lvl), 0);
        cold_start();
        check("cold_color", int'(bus.color), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
